// File: rtl/init_sequencer.sv
// Bring-up sequencer: walks UNITS peripherals through a request/acknowledge init handshake.
// Optional per-unit timeout with fail reporting is compiled in when INIT_SEQ_TIMEOUT_EN is defined.
module init_sequencer #(
   parameter int UNITS         = 4,
   parameter int TIMEOUTCYCLES = 4096,
   parameter int SETTLECYCLES  = 16
) (
   input  logic                                 clk,
   input  logic                                 sync_rst_n,
   input  logic                                 clk_en,
   input  logic                                 init_pulse_in,
   input  logic                                 sync_rst_pulse_in,
   output logic [UNITS-1:0]                     init_req_out,
   input  logic [UNITS-1:0]                     init_ack_in,
   output logic [((UNITS > 1) ? $clog2(UNITS) : 1)-1:0] cur_unit_out,
   output logic                                 busy_out,
   output logic                                 ready_out,
   output logic [UNITS-1:0]                     fail_mask_out
);

   localparam int CUR_W = (UNITS > 1) ? $clog2(UNITS) : 1;
`ifdef INIT_SEQ_TIMEOUT_EN
   localparam int CNT_SPAN = (TIMEOUTCYCLES > SETTLECYCLES) ? TIMEOUTCYCLES : SETTLECYCLES;
`else
   localparam int CNT_SPAN = SETTLECYCLES;
`endif
   localparam int CNT_W = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLECYCLES - 1);
   localparam logic [CUR_W-1:0] LAST_UNIT   = CUR_W'(UNITS - 1);
`ifdef INIT_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUTCYCLES - 1);
`endif

   if (UNITS < 1 || UNITS > 16) begin : g_bad_units
      $error("init_sequencer: UNITS must be in 1..16");
   end
   if (TIMEOUTCYCLES < 1) begin : g_bad_timeout
      $error("init_sequencer: TIMEOUTCYCLES must be at least 1");
   end
   if (SETTLECYCLES < 1) begin : g_bad_settle
      $error("init_sequencer: SETTLECYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SETTLE,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CUR_W-1:0] cur_q,   cur_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [UNITS-1:0] req_q,   req_d;
   logic             busy_q,  busy_d;
   logic             ready_q, ready_d;
`ifdef INIT_SEQ_TIMEOUT_EN
   logic [UNITS-1:0] fail_q,  fail_d;
`endif

   logic ack_cur;
   assign ack_cur = init_ack_in[cur_q];

   // One counter serves both REQ (timeout) and SETTLE (ack-low run); it is zeroed on every state entry.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
`ifdef INIT_SEQ_TIMEOUT_EN
      fail_d  = fail_q;
`endif
      if (clk_en) begin
         if (sync_rst_pulse_in) begin
            state_d = IDLE;
            cur_d   = '0;
            cnt_d   = '0;
`ifdef INIT_SEQ_TIMEOUT_EN
            fail_d  = '0;
`endif
         end else begin
            unique case (state_q)
               IDLE, DONE: begin
                  if (init_pulse_in) begin
                     state_d = REQ;
                     cur_d   = '0;
                     cnt_d   = '0;
`ifdef INIT_SEQ_TIMEOUT_EN
                     fail_d  = '0;
`endif
                  end
               end
               REQ: begin
                  if (ack_cur) begin
                     state_d = SETTLE;
                     cnt_d   = '0;
                  end
`ifdef INIT_SEQ_TIMEOUT_EN
                  else if (cnt_q == TIMEOUT_LAST) begin
                     fail_d[cur_q] = 1'b1;
                     state_d       = SETTLE;
                     cnt_d         = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
`endif
               end
               SETTLE: begin
                  // A unit still holding its ack restarts the quiet period.
                  if (ack_cur) begin
                     cnt_d = '0;
                  end else if (cnt_q == SETTLE_LAST) begin
                     cnt_d = '0;
                     if (cur_q == LAST_UNIT) begin
                        state_d = DONE;
                     end else begin
                        state_d = REQ;
                        cur_d   = cur_q + 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end

      // Outputs are decoded from the next state so they leave the register aligned with it.
      req_d = '0;
      if (state_d == REQ) begin
         req_d[cur_d] = 1'b1;
      end
      busy_d  = (state_d == REQ) || (state_d == SETTLE);
      ready_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values together.
      if (!sync_rst_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
         req_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
`ifdef INIT_SEQ_TIMEOUT_EN
         fail_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
`ifdef INIT_SEQ_TIMEOUT_EN
         fail_q  <= fail_d;
`endif
      end
   end

   assign init_req_out  = req_q;
   assign cur_unit_out  = cur_q;
   assign busy_out      = busy_q;
   assign ready_out     = ready_q;
`ifdef INIT_SEQ_TIMEOUT_EN
   assign fail_mask_out = fail_q;
`else
   assign fail_mask_out = '0;
`endif

endmodule

// File: tb/tb_init_sequencer.sv
// Self-checking bench for init_sequencer: directed vector table, directed multi-cycle scenarios,
// and randomized runs against a per-unit timeline model.
module tb_init_sequencer;

   localparam int UNITS = 4;
   localparam int TO    = 8;
   localparam int ST    = 16;
`ifdef INIT_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             sync_rst_n, clk_en, init_pulse, rst_pulse;
   logic [UNITS-1:0] ack, req, fail;
   logic [1:0]       cur;
   logic             busy, ready;

   always #5 clk = ~clk;

   init_sequencer #(
      .UNITS(UNITS),
      .TIMEOUTCYCLES(TO),
      .SETTLECYCLES(ST)
   ) dut (
      .clk(clk),
      .sync_rst_n(sync_rst_n),
      .clk_en(clk_en),
      .init_pulse_in(init_pulse),
      .sync_rst_pulse_in(rst_pulse),
      .init_req_out(req),
      .init_ack_in(ack),
      .cur_unit_out(cur),
      .busy_out(busy),
      .ready_out(ready),
      .fail_mask_out(fail)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: unit u owns qualified steps [start_s[u], start_s[u+1]); step 1 is the init edge.
   int d_len[UNITS];      // responder delay: ack seen on the d-th qualified edge of the request
   int h_len[UNITS];      // extra qualified cycles the ack is held after the request drops
   int r_len[UNITS];
   bit failed[UNITS];
   int start_s[UNITS+1];

   function automatic void plan();
      start_s[0] = 1;
      for (int u = 0; u < UNITS; u++) begin
         failed[u]    = TO_EN && (d_len[u] > TO);
         r_len[u]     = failed[u] ? TO : d_len[u];
         start_s[u+1] = start_s[u] + r_len[u] + (failed[u] ? 0 : h_len[u]) + ST;
      end
   endfunction

   function automatic int unit_at(input int t);
      unit_at = -1;
      for (int u = 0; u < UNITS; u++)
         if (t >= start_s[u] && t < start_s[u+1]) unit_at = u;
   endfunction

   function automatic logic [UNITS-1:0] exp_req(input int t);
      int u;
      exp_req = '0;
      u = unit_at(t);
      if (u >= 0 && t < start_s[u] + r_len[u]) exp_req[u] = 1'b1;
   endfunction

   function automatic logic [UNITS-1:0] exp_fail(input int t);
      exp_fail = '0;
      for (int u = 0; u < UNITS; u++)
         if (t >= 1 && failed[u] && t >= start_s[u] + r_len[u]) exp_fail[u] = 1'b1;
   endfunction

   // Ack to present after step t (it is sampled by the next qualified edge).
   function automatic logic [UNITS-1:0] exp_ack(input int t);
      exp_ack = '0;
      for (int u = 0; u < UNITS; u++)
         if (!failed[u] && t >= start_s[u] + d_len[u] - 1 && t <= start_s[u] + r_len[u] + h_len[u] - 1)
            exp_ack[u] = 1'b1;
   endfunction

   int               first_ready_idx, first_req1_step, req2_hi_cycles;
   logic [UNITS-1:0] last_fail;

   // mode 0: clk_en always 1, mode 1: alternating 1/0, mode 2: random.
   task automatic run(input int mode, input int abort_at);
      int               t;
      int               cyc;
      int               stop_t;
      int               u;
      logic [UNITS-1:0] noise;
      t   = 0;
      cyc = 0;
      plan();
      stop_t          = (abort_at > 0) ? abort_at : start_s[UNITS] + 3;
      first_ready_idx = -1;
      first_req1_step = -1;
      req2_hi_cycles  = 0;
      while (t < stop_t && cyc < 4000) begin
         if (t == 0) begin
            clk_en     = 1'b1;
            init_pulse = 1'b1;
         end else begin
            case (mode)
               0:       clk_en = 1'b1;
               1:       clk_en = (cyc % 2 == 0);
               default: clk_en = ($urandom_range(3) != 0);
            endcase
            init_pulse = (t < start_s[UNITS]) && ($urandom_range(7) == 0);
         end
         rst_pulse = 1'b0;
         u     = unit_at(t);
         noise = '0;
         for (int v = 0; v < UNITS; v++)
            if (v < u) noise[v] = 1'($urandom_range(1));
         ack = exp_ack(t) | noise;
         @(posedge clk);
         if (clk_en) t++;
         @(negedge clk);
         u = unit_at(t);
         check("run_req", req, exp_req(t));
         check("run_busy", busy, u >= 0);
         check("run_ready", ready, t >= start_s[UNITS]);
         check("run_fail", fail, exp_fail(t));
         if (u >= 0) check("run_cur", cur, u);
         if (ready === 1'b1 && first_ready_idx < 0) first_ready_idx = cyc;
         if (req[1] === 1'b1 && first_req1_step < 0) first_req1_step = t;
         if (req[2] === 1'b1) req2_hi_cycles++;
         cyc++;
      end
      check("run_bound", t >= stop_t, 1);
      last_fail  = fail;
      init_pulse = 1'b0;
      if (abort_at > 0) begin
         clk_en     = 1'b1;
         rst_pulse  = 1'b1;
         init_pulse = 1'b1;
         ack        = '0;
         @(posedge clk);
         @(negedge clk);
         check("abort_req", req, 0);
         check("abort_busy", busy, 0);
         check("abort_ready", ready, 0);
         check("abort_fail", fail, 0);
         check("abort_cur", cur, 0);
         rst_pulse  = 1'b0;
         init_pulse = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("abort_idle", {req, busy, ready}, 0);
      end
   endtask

   typedef struct {
      string      name;
      logic       rst_n, en, init, abort;
      logic [3:0] ack;
      logic [3:0] req;
      logic       busy, ready;
      logic [1:0] cur;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int norm_idx;
      int ab;
      vecs[0]  = '{"rst_en0",        1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[1]  = '{"idle_hold",      1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[2]  = '{"init_gated",     1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[3]  = '{"abort_prio",     1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[4]  = '{"start",          1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0};
      vecs[5]  = '{"other_ack",      1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0001, 1'b1, 1'b0, 2'd0};
      vecs[6]  = '{"freeze",         1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0};
      vecs[7]  = '{"ack_drop",       1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0};
      vecs[8]  = '{"init_in_settle", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0};
      vecs[9]  = '{"abort",          1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[10] = '{"restart",        1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0};
      vecs[11] = '{"rst_en0_busy",   1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      vecs[12] = '{"idle_after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};

      for (int i = 0; i < 13; i++) begin
         sync_rst_n = vecs[i].rst_n;
         clk_en     = vecs[i].en;
         init_pulse = vecs[i].init;
         rst_pulse  = vecs[i].abort;
         ack        = vecs[i].ack;
         @(posedge clk);
         @(negedge clk);
         check({vecs[i].name, "_req"}, req, vecs[i].req);
         check({vecs[i].name, "_busy"}, busy, vecs[i].busy);
         check({vecs[i].name, "_ready"}, ready, vecs[i].ready);
         check({vecs[i].name, "_cur"}, cur, vecs[i].cur);
         check({vecs[i].name, "_fail"}, fail, 0);
      end

      // Normal sequence: every unit acks on its 4th request cycle.
      for (int u = 0; u < UNITS; u++) begin d_len[u] = 4; h_len[u] = 0; end
      run(0, 0);
      norm_idx = first_ready_idx;
      check("normal_ready_cycles", norm_idx, UNITS * (4 + ST));
      check("normal_fail", last_fail, 0);

      // Same sequence with clk_en alternating takes twice as long.
      run(1, 0);
      check("gated_ready_cycles", first_ready_idx, 2 * UNITS * (4 + ST));

      // Unit 2 effectively never responds.
      d_len = '{2, 3, 20, 2};
      run(0, 0);
      check("timeout_req2_cycles", req2_hi_cycles, TO_EN ? TO : 20);
      check("timeout_fail", last_fail, TO_EN ? 4'b0100 : 4'b0000);

      // Unit 0 acks on the final timeout cycle, unit 1 one cycle too late.
      d_len = '{TO, TO + 1, 1, 1};
      run(0, 0);
      check("collision_fail", last_fail, TO_EN ? 4'b0010 : 4'b0000);

      // Unit 0 keeps its ack 5 cycles past the request drop.
      d_len = '{1, 2, 2, 2};
      h_len = '{5, 0, 0, 0};
      run(0, 0);
      check("sticky_req1_start", first_req1_step, 1 + 1 + 5 + ST);

      // Abort with a coincident init while unit 1 is in REQ.
      d_len = '{1, 6, 1, 1};
      h_len = '{0, 0, 0, 0};
      run(0, 1 + 1 + ST + 2);

      // Randomized sequences, some aborted part-way.
      for (int r = 0; r < 10; r++) begin
         for (int u = 0; u < UNITS; u++) begin
            d_len[u] = $urandom_range(12, 1);
            h_len[u] = $urandom_range(3);
         end
         plan();
         ab = ($urandom_range(2) == 0) ? $urandom_range(start_s[UNITS] + 2, 1) : 0;
         run(2, ab);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/init_sequencer.md
# init_sequencer

Bring-up sequencer downstream of the top-level reset/flag generator. Consumes its one-cycle initialize pulse and reset pulse, then walks a fixed list of peripheral units one at a time through a request/acknowledge init handshake. Reports per-unit failures and raises a single system-ready flag once every unit has been handled. Runs in the system clock domain and advances only on qualified `clk_en` cycles.

## Interface
Parameters:
- `UNITS`, 4: number of peripheral units sequenced; legal range 1..16.
- `TIMEOUTCYCLES`, 4096: qualified cycles allowed per unit in REQ before it is declared failed; must be ≥1.
- `SETTLECYCLES`, 16: qualified cycles required with the acknowledge low before the next unit starts; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `sync_rst_n`  in  1  reset: synchronous, active-low; clears all state.
- `clk_en`  in  1  qualifies every state, counter and flag update.
- `init_pulse_in`  in  1  initialize pulse from the reset flag generator; starts a sequence.
- `sync_rst_pulse_in`  in  1  soft reset pulse from the reset flag generator; aborts and returns to IDLE.
- `init_req_out`  out  UNITS  one-hot init request to the unit being serviced.
- `init_ack_in`  in  UNITS  per-unit acknowledge; level, held until the request drops.
- `cur_unit_out`  out  max(1,$clog2(UNITS))  index of the unit being serviced.
- `busy_out`  out  1  high in REQ and SETTLE.
- `ready_out`  out  1  high in DONE.
- `fail_mask_out`  out  UNITS  bit set for each unit that timed out.

## Operation
- States: IDLE, REQ, SETTLE, DONE.
- State changes and counter updates happen only on edges where `clk_en`=1. Reset (`sync_rst_n`=0) is the exception and acts on any edge.
- **IDLE**
  - Outputs low, counters 0.
  - `init_pulse_in`=1 → REQ, unit 0, `fail_mask_out` cleared.
- **REQ**
  - `init_req_out[cur]`=1. The timeout counter increments each qualified cycle.
  - If `init_ack_in[cur]`=1 → SETTLE.
  - Else if the counter reaches `TIMEOUTCYCLES`-1 → set `fail_mask_out[cur]`, then SETTLE.
  - If the ack and the timeout limit occur on the same cycle, the ack wins and no fail bit is set.
  - Ack bits of other units are ignored.
- **SETTLE**
  - Request low. The settle counter counts qualified cycles with `init_ack_in[cur]`=0; it resets to 0 on any cycle the ack is high.
  - When the counter reaches `SETTLECYCLES`-1:
    - if `cur` = `UNITS`-1 → DONE;
    - else `cur`+1 → REQ with the timeout counter at 0.
- **DONE**
  - `ready_out`=1, held indefinitely.
  - `init_pulse_in`=1 → restart at REQ unit 0, mask cleared.
- **Abort**
  - `sync_rst_pulse_in`=1 in any state → IDLE, with counters, `cur` and `fail_mask_out` cleared.
  - It has priority over `init_pulse_in` on the same cycle.
- `init_pulse_in` during REQ or SETTLE is ignored.
- Counter width is $clog2 of the larger of the two cycle parameters. Counters never wrap: each stops at its limit because the state exits.

## Timing
- Reset values: `init_req_out`=0, `cur_unit_out`=0, `busy_out`=0, `ready_out`=0, `fail_mask_out`=0, state IDLE.
- All outputs are registered, with no combinational input→output paths.
- Start latency: `init_req_out[0]` rises on the edge that samples `init_pulse_in` with `clk_en`=1.
- Request-drop latency: the request falls on the edge sampling the ack; that is 1 qualified cycle.
- Per-unit minimum with an immediate ack: 1 REQ cycle plus `SETTLECYCLES` settle cycles.
- A fail bit is set on the same edge the request drops.
- Timeout: a non-responding unit spends exactly `TIMEOUTCYCLES` qualified cycles in REQ.
- `ready_out` rises on the edge leaving the last SETTLE.
- `clk_en`=0 freezes all state and outputs.

## Configuration
- Macro: `INIT_SEQ_TIMEOUT_EN`.
- Defined: timeout counter and fail logic are present, as described above.
- Undefined:
  - REQ waits for the ack indefinitely; `fail_mask_out` is tied to 0.
  - The timeout counter is removed and the counter width is $clog2(`SETTLECYCLES`).

## Test plan
- **Normal sequence.** `UNITS`=4, `SETTLECYCLES`=16, `clk_en`=1, each ack returned 3 cycles after its request. Pulse init → requests 0001, 0010, 0100, 1000 in order; `ready_out`=1 after 4×(4+16) cycles; `fail_mask_out`=0.
- **Timeout.** Macro defined, `TIMEOUTCYCLES`=8, unit 2 never acks → unit 2's request high exactly 8 cycles; `fail_mask_out`=0100; sequence continues to unit 3; `ready_out`=1.
- **Ack/timeout collision.** Ack on the final timeout cycle → no fail bit set; request drops next edge.
- **Abort mid-sequence.** `sync_rst_pulse_in` during unit 1 REQ together with `init_pulse_in` → next edge IDLE, all outputs 0; the coincident init is ignored.
- **Sticky ack.** Unit 0 holds its ack high 5 cycles after the request drops → unit 1's request is delayed until 16 consecutive ack-low cycles.
- **Clock-enable gating and reset.** `clk_en` toggled 1/0 → the sequence takes exactly 2× the cycles. `sync_rst_n`=0 with `clk_en`=0 → all outputs clear on the next edge.
